// File: rtl/uart_pkg.sv
// Shared widths, packer state encoding and timeout default
// for the UART receive word packer.
package uart_pkg;

   localparam int UART_BYTE_W     = 8;
   localparam int UART_WORD_W     = 16;
   localparam int DEFAULT_TIMEOUT = 20000;

   typedef enum logic {
      IDLE    = 1'b0,
      HAVE_LO = 1'b1
   } pack_state_e;

   function automatic logic [UART_WORD_W-1:0] make_word(
      input logic [UART_BYTE_W-1:0] hi,
      input logic [UART_BYTE_W-1:0] lo
   );
      return {hi, lo};
   endfunction

endpackage

// File: rtl/uart_rx_word_packer_if.sv
// Receiver-side byte strobe, host read port and status flags
// of the word packer.
interface uart_rx_word_packer_if
   import uart_pkg::*;
#(
   parameter int DEPTH = 8
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic                   received;
   logic [UART_BYTE_W-1:0] rx_byte;
   logic                   recv_error;
   logic                   rd_en;
   logic [UART_WORD_W-1:0] rd_data;
   logic                   rd_valid;
   logic                   empty;
   logic                   full;
   logic [CW-1:0]          count;
   logic                   overflow;
   logic                   frame_error;
   logic                   timeout_err;
   logic                   clr_flags;

   modport master (
      output received, rx_byte, recv_error,
      output rd_en, clr_flags,
      input  rd_data, rd_valid, empty, full, count,
      input  overflow, frame_error, timeout_err
   );

   modport slave (
      input  received, rx_byte, recv_error,
      input  rd_en, clr_flags,
      output rd_data, rd_valid, empty, full, count,
      output overflow, frame_error, timeout_err
   );

endinterface

// File: rtl/uart_word_fifo.sv
// Synchronous word FIFO with registered read port; a push
// into a full FIFO only succeeds when a pop frees a slot.
module uart_word_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     push_drop
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty     = (count == '0);
   assign full      = (count == (AW+1)'(DEPTH));
   assign do_pop    = pop & !empty;
   assign do_push   = push & (!full | do_pop);
   assign push_drop = push & full & !do_pop;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         pop_data <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) begin
            rd_ptr   <= rd_ptr + 1'b1;
            pop_data <= mem[rd_ptr];
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_word_packer.sv
// Pairs UART bytes into little-endian words, buffers them,
// and recovers from stalled or corrupted pairs.
module uart_rx_word_packer
   import uart_pkg::*;
#(
   parameter int DEPTH          = 8,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
   input logic                 clk,
   input logic                 rst,
   uart_rx_word_packer_if.slave bus
);
   localparam int TW = (TIMEOUT_CYCLES > 0) ?
                       $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TW-1:0] TMO_LAST =
      TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   pack_state_e            state;
   logic [UART_BYTE_W-1:0] lo_reg;
   logic [TW-1:0]          tmo_cnt;
   logic                   byte_ok;
   logic                   push;
   logic [UART_WORD_W-1:0] word;
   logic                   tmo_hit;
   logic                   push_drop;
   logic                   rd_valid_q;
   logic                   overflow_q;
   logic                   frame_q;
   logic                   timeout_q;

   assign byte_ok = bus.received & !bus.recv_error;
   assign push    = (state == HAVE_LO) & byte_ok;
   assign word    = make_word(bus.rx_byte, lo_reg);

   // a byte arriving in the expiry cycle still completes the word
   assign tmo_hit = (TIMEOUT_CYCLES != 0) &&
                    (state == HAVE_LO) &&
                    !bus.received && !bus.recv_error &&
                    (tmo_cnt == TMO_LAST);

   uart_word_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (UART_WORD_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (word),
      .pop       (bus.rd_en),
      .pop_data  (bus.rd_data),
      .empty     (bus.empty),
      .full      (bus.full),
      .count     (bus.count),
      .push_drop (push_drop)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         lo_reg  <= '0;
         tmo_cnt <= '0;
      end else if (bus.recv_error) begin
         state   <= IDLE;
         tmo_cnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.received) begin
                  lo_reg  <= bus.rx_byte;
                  tmo_cnt <= '0;
                  state   <= HAVE_LO;
               end
            end
            HAVE_LO: begin
               if (bus.received || tmo_hit) begin
                  state <= IDLE;
               end else if (tmo_cnt != '1) begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid_q <= 1'b0;
         overflow_q <= 1'b0;
         frame_q    <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         rd_valid_q <= bus.rd_en & !bus.empty;
         overflow_q <= push_drop |
                       (overflow_q & !bus.clr_flags);
         frame_q    <= bus.recv_error |
                       (frame_q & !bus.clr_flags);
         timeout_q  <= tmo_hit |
                       (timeout_q & !bus.clr_flags);
      end
   end

   assign bus.rd_valid    = rd_valid_q;
   assign bus.overflow    = overflow_q;
   assign bus.frame_error = frame_q;
   assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Directed vector bench for the UART word packer.
module tb_uart_rx_word_packer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass = 0;
   int   n_total = 0;

   uart_rx_word_packer_if #(.DEPTH(8)) bus ();

   uart_rx_word_packer #(
      .DEPTH          (8),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  lo;
      logic [7:0]  hi;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h",
                    name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.received = 1'b1;
      bus.rx_byte  = b;
      tick();
      bus.received = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] lo,
                            input logic [7:0] hi);
      send_byte(lo);
      send_byte(hi);
   endtask

   task automatic pop_chk(input string name,
                          input logic [15:0] exp);
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      chk({name, "_valid"}, bus.rd_valid, 1);
      chk({name, "_data"}, bus.rd_data, exp);
   endtask

   task automatic clear_flags();
      bus.clr_flags = 1'b1;
      tick();
      bus.clr_flags = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_rd_data"}, bus.rd_data, 0);
      chk({tag, "_rd_valid"}, bus.rd_valid, 0);
      chk({tag, "_empty"}, bus.empty, 1);
      chk({tag, "_full"}, bus.full, 0);
      chk({tag, "_count"}, bus.count, 0);
      chk({tag, "_overflow"}, bus.overflow, 0);
      chk({tag, "_frame"}, bus.frame_error, 0);
      chk({tag, "_timeout"}, bus.timeout_err, 0);
   endtask

   initial begin
      vecs[0] = '{lo: 8'h00, hi: 8'h80, exp: 16'h8000};
      vecs[1] = '{lo: 8'h0F, hi: 8'hF0, exp: 16'hF00F};
      vecs[2] = '{lo: 8'h80, hi: 8'h00, exp: 16'h0080};
      vecs[3] = '{lo: 8'hFF, hi: 8'hFF, exp: 16'hFFFF};

      bus.received   = 1'b0;
      bus.rx_byte    = 8'h00;
      bus.recv_error = 1'b0;
      bus.rd_en      = 1'b0;
      bus.clr_flags  = 1'b0;

      tick();
      tick();
      chk_reset_vals("rst");
      rst = 1'b0;
      tick();

      // byte order through the table
      foreach (vecs[i]) send_word(vecs[i].lo, vecs[i].hi);
      chk("t1_count", bus.count, 4);
      foreach (vecs[i]) pop_chk($sformatf("t1_pop%0d", i),
                                vecs[i].exp);
      tick();
      chk("t1_valid_lo", bus.rd_valid, 0);
      chk("t1_empty", bus.empty, 1);

      // pop on empty while a push lands: no fall-through
      send_byte(8'h66);
      bus.received = 1'b1;
      bus.rx_byte  = 8'h77;
      bus.rd_en    = 1'b1;
      tick();
      bus.received = 1'b0;
      bus.rd_en    = 1'b0;
      chk("pe_valid", bus.rd_valid, 0);
      chk("pe_hold", bus.rd_data, 16'hFFFF);
      chk("pe_count", bus.count, 1);
      pop_chk("pe_pop", 16'h7766);

      // timeout expires on the 100th waiting cycle
      send_byte(8'hFF);
      for (int i = 0; i < 99; i++) tick();
      chk("tmo_early", bus.timeout_err, 0);
      tick();
      chk("tmo_set", bus.timeout_err, 1);
      chk("tmo_count", bus.count, 0);
      send_word(8'h11, 8'h22);
      pop_chk("tmo_pop", 16'h2211);
      clear_flags();
      chk("tmo_clr", bus.timeout_err, 0);

      // framing error, including one with a byte strobe
      send_byte(8'hAA);
      bus.recv_error = 1'b1;
      bus.received   = 1'b1;
      bus.rx_byte    = 8'h77;
      tick();
      bus.recv_error = 1'b0;
      bus.received   = 1'b0;
      chk("fe_set", bus.frame_error, 1);
      send_word(8'h01, 8'h02);
      chk("fe_count", bus.count, 1);
      pop_chk("fe_pop", 16'h0201);
      chk("fe_empty", bus.empty, 1);
      clear_flags();
      chk("fe_clr", bus.frame_error, 0);

      // fill past capacity
      for (int i = 0; i < 9; i++) begin
         send_word(8'(i), 8'(8'hA0 + i));
         if (i == 7) begin
            chk("ov_full8", bus.full, 1);
            chk("ov_pre", bus.overflow, 0);
         end
      end
      chk("ov_full", bus.full, 1);
      chk("ov_count", bus.count, 8);
      chk("ov_set", bus.overflow, 1);
      clear_flags();
      chk("ov_clr", bus.overflow, 0);
      pop_chk("ov_first", 16'hA000);
      chk("ov_count7", bus.count, 7);
      send_word(8'h09, 8'hA9);
      chk("ov_refull", bus.full, 1);

      // push and pop together while full
      send_byte(8'h5A);
      bus.received = 1'b1;
      bus.rx_byte  = 8'hC3;
      bus.rd_en    = 1'b1;
      tick();
      bus.received = 1'b0;
      bus.rd_en    = 1'b0;
      chk("fp_valid", bus.rd_valid, 1);
      chk("fp_data", bus.rd_data, 16'hA101);
      chk("fp_count", bus.count, 8);
      chk("fp_ovf", bus.overflow, 0);
      for (int i = 2; i < 8; i++)
         pop_chk($sformatf("fp_pop%0d", i),
                 {8'(8'hA0 + i), 8'(i)});
      pop_chk("fp_pop9", 16'hA909);
      pop_chk("fp_last", 16'hC35A);
      chk("fp_empty", bus.empty, 1);

      // async reset mid-word
      bus.recv_error = 1'b1;
      tick();
      bus.recv_error = 1'b0;
      for (int i = 0; i < 4; i++)
         send_word(8'(8'h40 + i), 8'h5C);
      pop_chk("ar_pop", 16'h5C40);
      send_byte(8'h99);
      chk("ar_count", bus.count, 3);
      chk("ar_frame", bus.frame_error, 1);
      #2;
      rst = 1'b1;
      #1;
      chk_reset_vals("ar");
      #1;
      rst = 1'b0;
      tick();
      send_word(8'h34, 8'h12);
      pop_chk("ar_word", 16'h1234);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
